win_detector: RTL and testbench

Sequential four-in-a-row detector for the Connect Four design. It sits directly downstream of `game_state` and consumes the registered `green_grid` / `blue_grid` boards. On each `start` pulse it snapshots both boards and scans every cell as a line anchor, one anchor per cycle. It then reports the winner, a mask of the winning cells (for blinking on the LED matrix) and a draw flag.

---
 rtl/win_detector_pkg.sv | 31 +++
 rtl/win_detector_if.sv | 41 ++++
 rtl/line_checker.sv | 79 +++++++
 rtl/win_detector.sv | 135 +++++++++++++
 tb/tb_win_detector.sv | 270 +++++++++++++++++++++++++++
 5 files changed

// File: rtl/win_detector_pkg.sv
// Shared types and defaults for the Connect Four win detector.
// Holds the board geometry defaults, the board/winner/state types and a
// small helper that folds per-anchor hits into the running winner code.
package win_detector_pkg;

    localparam int DEFAULT_GRID_N  = 8;
    localparam int DEFAULT_WIN_LEN = 4;

    // One full board at the default size, indexed [row][col], row 0 at the top
    typedef logic [DEFAULT_GRID_N-1:0][DEFAULT_GRID_N-1:0] grid_t;

    // Bit 0 flags a green line, bit 1 flags a blue line
    typedef enum logic [1:0] {
        NONE  = 2'b00,
        GREEN = 2'b01,
        BLUE  = 2'b10,
        BOTH  = 2'b11
    } winner_t;

    typedef enum logic [1:0] {
        IDLE = 2'b00,
        SCAN = 2'b01,
        DONE = 2'b10
    } scan_state_t;

    // A colour that has won once stays won for the rest of the scan
    function automatic winner_t mergeWinner(winner_t cur, logic greenHit, logic blueHit);
        return winner_t'(cur | {blueHit, greenHit});
    endfunction

endpackage

// File: rtl/win_detector_if.sv
// Bundle between game_state (master) and the win detector (slave).
// game_state pulses start with the committed boards; the detector answers
// with busy/done and the winner, draw flag and blink mask.
interface win_detector_if
    import win_detector_pkg::*;
#(
    parameter int GRID_N = DEFAULT_GRID_N
);

    logic                           start;
    logic [GRID_N-1:0][GRID_N-1:0]  green_grid;
    logic [GRID_N-1:0][GRID_N-1:0]  blue_grid;
    logic                           busy;
    logic                           done;
    logic [1:0]                     winner;
    logic                           draw;
    logic [GRID_N-1:0][GRID_N-1:0]  win_mask;

    modport master (
        output start,
        output green_grid,
        output blue_grid,
        input  busy,
        input  done,
        input  winner,
        input  draw,
        input  win_mask
    );

    modport slave (
        input  start,
        input  green_grid,
        input  blue_grid,
        output busy,
        output done,
        output winner,
        output draw,
        output win_mask
    );

endinterface

// File: rtl/line_checker.sv
// Combinational check of the four lines that start at one anchor cell.
// Horizontal, vertical, down-right and down-left runs of WIN_LEN cells are
// tested against one board; lines that would leave the board are skipped,
// so nothing ever wraps from one row into the next.
module line_checker
    import win_detector_pkg::*;
#(
    parameter int GRID_N  = DEFAULT_GRID_N,
    parameter int WIN_LEN = DEFAULT_WIN_LEN,
    localparam int RW     = (GRID_N > 1) ? $clog2(GRID_N) : 1
) (
    input  logic [GRID_N-1:0][GRID_N-1:0] grid_i,
    input  logic [RW-1:0]                 row_i,
    input  logic [RW-1:0]                 col_i,
    output logic [3:0]                    dirHit_o,
    output logic [GRID_N-1:0][GRID_N-1:0] hitMask_o
);

    typedef logic [GRID_N-1:0][GRID_N-1:0] board_t;

    int     anchorRow;
    int     anchorCol;
    logic   fitsDown;
    logic   fitsRight;
    logic   fitsLeft;
    logic   hitH;
    logic   hitV;
    logic   hitDR;
    logic   hitDL;
    board_t maskH;
    board_t maskV;
    board_t maskDR;
    board_t maskDL;

    // Decide which directions stay on the board, widening to int so the left bound never underflows
    always_comb begin
        anchorRow = int'(row_i);
        anchorCol = int'(col_i);
        fitsDown  = (anchorRow + WIN_LEN - 1) <= (GRID_N - 1);
        fitsRight = (anchorCol + WIN_LEN - 1) <= (GRID_N - 1);
        fitsLeft  = anchorCol >= (WIN_LEN - 1);
    end

    // Walk each in-range line, AND its cells together and collect its cells into a mask
    always_comb begin
        hitH   = fitsRight;
        hitV   = fitsDown;
        hitDR  = fitsDown && fitsRight;
        hitDL  = fitsDown && fitsLeft;
        maskH  = '0;
        maskV  = '0;
        maskDR = '0;
        maskDL = '0;
        for (int k = 0; k < WIN_LEN; k++) begin
            if (fitsRight) begin
                hitH = hitH & grid_i[RW'(anchorRow)][RW'(anchorCol + k)];
                maskH[RW'(anchorRow)][RW'(anchorCol + k)] = 1'b1;
            end
            if (fitsDown) begin
                hitV = hitV & grid_i[RW'(anchorRow + k)][RW'(anchorCol)];
                maskV[RW'(anchorRow + k)][RW'(anchorCol)] = 1'b1;
            end
            if (fitsDown && fitsRight) begin
                hitDR = hitDR & grid_i[RW'(anchorRow + k)][RW'(anchorCol + k)];
                maskDR[RW'(anchorRow + k)][RW'(anchorCol + k)] = 1'b1;
            end
            if (fitsDown && fitsLeft) begin
                hitDL = hitDL & grid_i[RW'(anchorRow + k)][RW'(anchorCol - k)];
                maskDL[RW'(anchorRow + k)][RW'(anchorCol - k)] = 1'b1;
            end
        end
        dirHit_o  = {hitDL, hitDR, hitV, hitH};
        hitMask_o = (hitH  ? maskH  : '0)
                  | (hitV  ? maskV  : '0)
                  | (hitDR ? maskDR : '0)
                  | (hitDL ? maskDL : '0);
    end

endmodule

// File: rtl/win_detector.sv
// Sequential four-in-a-row detector fed by game_state.
// A start pulse snapshots both boards, then one anchor cell is checked per
// cycle for GRID_N*GRID_N cycles. Winner and blink mask accumulate over the
// whole scan; done pulses once with draw settled, and results hold until
// the next start or reset.
module win_detector
    import win_detector_pkg::*;
#(
    parameter int GRID_N  = DEFAULT_GRID_N,
    parameter int WIN_LEN = DEFAULT_WIN_LEN
) (
    input  logic          clock,
    input  logic          rst,
    win_detector_if.slave bus
);

    localparam int CELLS = GRID_N * GRID_N;
    localparam int IDXW  = (CELLS > 1) ? $clog2(CELLS) : 1;
    localparam int RW    = (GRID_N > 1) ? $clog2(GRID_N) : 1;
    localparam logic [IDXW-1:0] LAST_IDX = IDXW'(CELLS - 1);
    localparam logic [IDXW-1:0] ROW_LEN  = IDXW'(GRID_N);

    typedef logic [GRID_N-1:0][GRID_N-1:0] board_t;

    scan_state_t     state_q, state_d;
    logic [IDXW-1:0] idx_q, idx_d;
    board_t          greenSnap_q, greenSnap_d;
    board_t          blueSnap_q, blueSnap_d;
    board_t          winMask_q, winMask_d;
    winner_t         winner_q, winner_d;
    logic            draw_q, draw_d;

    logic [RW-1:0]   anchorRow;
    logic [RW-1:0]   anchorCol;
    logic [3:0]      greenHits;
    logic [3:0]      blueHits;
    board_t          greenMask;
    board_t          blueMask;

    assign anchorRow = RW'(idx_q / ROW_LEN);
    assign anchorCol = RW'(idx_q % ROW_LEN);

    line_checker #(
        .GRID_N  (GRID_N),
        .WIN_LEN (WIN_LEN)
    ) greenChecker (
        .grid_i    (greenSnap_q),
        .row_i     (anchorRow),
        .col_i     (anchorCol),
        .dirHit_o  (greenHits),
        .hitMask_o (greenMask)
    );

    line_checker #(
        .GRID_N  (GRID_N),
        .WIN_LEN (WIN_LEN)
    ) blueChecker (
        .grid_i    (blueSnap_q),
        .row_i     (anchorRow),
        .col_i     (anchorCol),
        .dirHit_o  (blueHits),
        .hitMask_o (blueMask)
    );

    // Next-state logic: a start in any state relaunches the scan from a fresh snapshot
    always_comb begin
        state_d     = state_q;
        idx_d       = idx_q;
        greenSnap_d = greenSnap_q;
        blueSnap_d  = blueSnap_q;
        winMask_d   = winMask_q;
        winner_d    = winner_q;
        draw_d      = draw_q;

        if (bus.start) begin
            state_d     = SCAN;
            idx_d       = '0;
            greenSnap_d = bus.green_grid;
            blueSnap_d  = bus.blue_grid;
            winMask_d   = '0;
            winner_d    = NONE;
            draw_d      = 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    state_d = IDLE;
                end
                SCAN: begin
                    winMask_d = winMask_q | greenMask | blueMask;
                    winner_d  = mergeWinner(winner_q, |greenHits, |blueHits);
                    if (idx_q == LAST_IDX) begin
                        state_d = DONE;
                        draw_d  = (winner_d == NONE) && (&(greenSnap_q | blueSnap_q));
                    end else begin
                        idx_d = idx_q + 1'b1;
                    end
                end
                DONE: begin
                    state_d = IDLE;
                end
                default: begin
                    state_d = IDLE;
                end
            endcase
        end
    end

    // State and result registers, cleared immediately by reset
    always_ff @(posedge clock or posedge rst) begin
        if (rst) begin
            state_q     <= IDLE;
            idx_q       <= '0;
            greenSnap_q <= '0;
            blueSnap_q  <= '0;
            winMask_q   <= '0;
            winner_q    <= NONE;
            draw_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            idx_q       <= idx_d;
            greenSnap_q <= greenSnap_d;
            blueSnap_q  <= blueSnap_d;
            winMask_q   <= winMask_d;
            winner_q    <= winner_d;
            draw_q      <= draw_d;
        end
    end

    assign bus.busy     = (state_q == SCAN);
    assign bus.done     = (state_q == DONE);
    assign bus.winner   = winner_q;
    assign bus.draw     = draw_q;
    assign bus.win_mask = winMask_q;

endmodule

// File: tb/tb_win_detector.sv
// Self-checking bench for win_detector: a table of boards with expected
// results, a scoreboard queue filled at each start and drained at each done,
// and hand-written restart, start-during-done and mid-scan reset sequences.
module tb_win_detector;
    import win_detector_pkg::*;

    typedef struct {
        string      name;
        grid_t      green;
        grid_t      blue;
        logic [1:0] expWinner;
        logic       expDraw;
        grid_t      expMask;
    } vector_t;

    typedef struct {
        string      name;
        logic [1:0] winner;
        logic       draw;
        grid_t      mask;
    } expect_t;

    logic    clock = 1'b0;
    logic    rst;
    int      checks = 0;
    int      errors = 0;
    vector_t vectors[$];
    expect_t scoreboard[$];
    expect_t lastExp;

    win_detector_if #(.GRID_N(DEFAULT_GRID_N)) bus ();

    win_detector #(
        .GRID_N  (DEFAULT_GRID_N),
        .WIN_LEN (DEFAULT_WIN_LEN)
    ) dut (
        .clock (clock),
        .rst   (rst),
        .bus   (bus)
    );

    always #5 clock = ~clock;

    function automatic grid_t setCell(grid_t g, int r, int c);
        grid_t t;
        t = g;
        t[r[2:0]][c[2:0]] = 1'b1;
        return t;
    endfunction

    function automatic grid_t clearCell(grid_t g, int r, int c);
        grid_t t;
        t = g;
        t[r[2:0]][c[2:0]] = 1'b0;
        return t;
    endfunction

    function automatic vector_t makeVec(string name, grid_t g, grid_t b, logic [1:0] w, logic d, grid_t m);
        vector_t v;
        v.name      = name;
        v.green     = g;
        v.blue      = b;
        v.expWinner = w;
        v.expDraw   = d;
        v.expMask   = m;
        return v;
    endfunction

    task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("[TB] FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Called at a negedge: pulse start for one edge, log the expectation, then scramble the inputs
    task automatic applyStimulus(input string name, input grid_t g, input grid_t b,
                                 input logic [1:0] w, input logic d, input grid_t m);
        expect_t e;
        bus.green_grid = g;
        bus.blue_grid  = b;
        bus.start      = 1'b1;
        e.name   = name;
        e.winner = w;
        e.draw   = d;
        e.mask   = m;
        scoreboard.push_back(e);
        @(posedge clock);
        @(negedge clock);
        bus.start      = 1'b0;
        bus.green_grid = {$urandom, $urandom};
        bus.blue_grid  = {$urandom, $urandom};
    endtask

    // Starts at the negedge after the start edge; returns at the negedge where done is seen
    task automatic waitForDone();
        int      edges = 0;
        int      busyCycles = 0;
        expect_t e;
        while (bus.done !== 1'b1 && edges < 200) begin
            if (bus.busy === 1'b1) busyCycles++;
            @(posedge clock);
            edges++;
            @(negedge clock);
        end
        checkOutput("doneLatency", 64'(edges), 64'd64);
        checkOutput("busyCycles", 64'(busyCycles), 64'd64);
        checkOutput("busyAtDone", 64'(bus.busy), 64'd0);
        if (scoreboard.size() == 0) begin
            checks++;
            errors++;
            $display("[TB] FAIL scoreboard: got no pending entry expected one");
        end else begin
            e = scoreboard.pop_front();
            lastExp = e;
            checkOutput({e.name, ".winner"}, 64'(bus.winner), 64'(e.winner));
            checkOutput({e.name, ".draw"}, 64'(bus.draw), 64'(e.draw));
            checkOutput({e.name, ".mask"}, bus.win_mask, e.mask);
        end
    endtask

    // One cycle after done: the pulse is gone and the results are still held
    task automatic checkHold();
        @(posedge clock);
        @(negedge clock);
        checkOutput({lastExp.name, ".donePulse"}, 64'(bus.done), 64'd0);
        checkOutput({lastExp.name, ".idleBusy"}, 64'(bus.busy), 64'd0);
        checkOutput({lastExp.name, ".winnerHeld"}, 64'(bus.winner), 64'(lastExp.winner));
        checkOutput({lastExp.name, ".maskHeld"}, bus.win_mask, lastExp.mask);
    endtask

    task automatic checkAllZero(input string name);
        checkOutput({name, ".busy"}, 64'(bus.busy), 64'd0);
        checkOutput({name, ".done"}, 64'(bus.done), 64'd0);
        checkOutput({name, ".winner"}, 64'(bus.winner), 64'd0);
        checkOutput({name, ".draw"}, 64'(bus.draw), 64'd0);
        checkOutput({name, ".mask"}, bus.win_mask, 64'd0);
    endtask

    initial begin
        grid_t g;
        grid_t b;
        grid_t m;
        grid_t altGreen;
        grid_t altBlue;
        int    donePulses;

        rst            = 1'b1;
        bus.start      = 1'b0;
        bus.green_grid = '0;
        bus.blue_grid  = '0;

        vectors.push_back(makeVec("empty", '0, '0, 2'b00, 1'b0, '0));

        g = '0;
        for (int c = 2; c <= 5; c++) g = setCell(g, 7, c);
        vectors.push_back(makeVec("greenRow7", g, '0, 2'b01, 1'b0, g));

        b = '0;
        m = '0;
        for (int k = 0; k < 4; k++) begin
            b = setCell(b, 4 + k, 7 - k);
            m = setCell(m, 4 + k, 7 - k);
        end
        for (int c = 0; c <= 2; c++) b = setCell(b, 7, c);
        vectors.push_back(makeVec("blueDiagEdge", '0, b, 2'b10, 1'b0, m));

        altGreen = '0;
        altBlue  = '0;
        for (int r = 0; r < 8; r++) begin
            for (int c = 0; c < 8; c++) begin
                if ((((c / 2) + r) % 2) == 0) altGreen = setCell(altGreen, r, c);
                else                          altBlue  = setCell(altBlue, r, c);
            end
        end
        vectors.push_back(makeVec("fullDraw", altGreen, altBlue, 2'b00, 1'b1, '0));

        g = '0;
        for (int c = 0; c <= 4; c++) g = setCell(g, 7, c);
        vectors.push_back(makeVec("greenFive", g, '0, 2'b01, 1'b0, g));

        g = '0;
        g = setCell(g, 3, 6);
        g = setCell(g, 3, 7);
        g = setCell(g, 4, 0);
        g = setCell(g, 4, 1);
        vectors.push_back(makeVec("rowWrap", g, '0, 2'b00, 1'b0, '0));

        g = '0;
        b = '0;
        for (int r = 0; r < 4; r++) g = setCell(g, r, 0);
        for (int r = 4; r < 8; r++) b = setCell(b, r, 7);
        vectors.push_back(makeVec("bothWin", g, b, 2'b11, 1'b0, g | b));

        g = altGreen;
        b = altBlue;
        for (int r = 0; r < 4; r++) begin
            g = setCell(g, r, 0);
            b = clearCell(b, r, 0);
        end
        m = '0;
        for (int r = 0; r <= 4; r++) m = setCell(m, r, 0);
        vectors.push_back(makeVec("fullWithWin", g, b, 2'b01, 1'b0, m));

        repeat (2) @(posedge clock);
        @(negedge clock);
        checkAllZero("reset");
        rst = 1'b0;
        @(negedge clock);

        foreach (vectors[i]) begin
            applyStimulus(vectors[i].name, vectors[i].green, vectors[i].blue,
                          vectors[i].expWinner, vectors[i].expDraw, vectors[i].expMask);
            waitForDone();
            checkHold();
        end

        // Restart at T0+30: the first scan is abandoned and the second finishes 64 edges after the restart
        applyStimulus("restartFirst", vectors[1].green, vectors[1].blue,
                      vectors[1].expWinner, vectors[1].expDraw, vectors[1].expMask);
        donePulses = 0;
        repeat (29) begin
            @(posedge clock);
            @(negedge clock);
            if (bus.done === 1'b1) donePulses++;
        end
        checkOutput("restart.noEarlyDone", 64'(donePulses), 64'd0);
        scoreboard.delete();
        applyStimulus("restartSecond", vectors[2].green, vectors[2].blue,
                      vectors[2].expWinner, vectors[2].expDraw, vectors[2].expMask);
        waitForDone();
        checkHold();

        // Start arriving in the done cycle launches a new scan straight away
        applyStimulus("chainFirst", vectors[4].green, vectors[4].blue,
                      vectors[4].expWinner, vectors[4].expDraw, vectors[4].expMask);
        waitForDone();
        applyStimulus("chainSecond", vectors[6].green, vectors[6].blue,
                      vectors[6].expWinner, vectors[6].expDraw, vectors[6].expMask);
        waitForDone();
        checkHold();

        // Reset mid-scan: everything drops at once and no done follows
        g = '0;
        for (int c = 0; c < 4; c++) g = setCell(g, 0, c);
        applyStimulus("resetRun", g, '0, 2'b01, 1'b0, g);
        repeat (20) @(posedge clock);
        @(negedge clock);
        rst = 1'b1;
        #1;
        checkAllZero("midScanReset");
        scoreboard.delete();
        @(posedge clock);
        @(negedge clock);
        rst = 1'b0;
        donePulses = 0;
        repeat (100) begin
            @(posedge clock);
            @(negedge clock);
            if (bus.done === 1'b1) donePulses++;
        end
        checkOutput("reset.noDone", 64'(donePulses), 64'd0);
        checkOutput("reset.idleBusy", 64'(bus.busy), 64'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
